// File: rtl/prod_accum.sv
// Group accumulator for multiplier products: sums unsigned beats into a wide
// accumulator and hands each closed group off on a valid/ready result port.
module prod_accum #(
    parameter int IN_W      = 8,
    parameter int ACC_W     = 16,
    parameter int MAX_TERMS = 16,
    parameter int SAT       = 0
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [IN_W-1:0]                  in_p,
    input  logic                             in_valid,
    input  logic                             in_last,
    output logic                             in_ready,
    input  logic                             clr,
    output logic [ACC_W-1:0]                 out_sum,
    output logic [$clog2(MAX_TERMS+1)-1:0]   out_count,
    output logic                             out_ovf,
    output logic                             out_valid,
    input  logic                             out_ready
);

    localparam int CW = $clog2(MAX_TERMS + 1);

    localparam logic [0:0] ST_ACC = 1'b0;
    localparam logic [0:0] ST_OUT = 1'b1;

    logic [0:0]       state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [CW-1:0]    count_q, count_d;
    logic             ovf_q, ovf_d;
    logic [ACC_W-1:0] sum_q, sum_d;
    logic [CW-1:0]    ocnt_q, ocnt_d;
    logic             oovf_q, oovf_d;

    logic             accept_s;
    logic [ACC_W:0]   sum_s;
    logic             ovf_next_s;
    logic [ACC_W-1:0] acc_next_s;
    logic [CW-1:0]    cnt_next_s;
    logic             close_s;

    // Ready is gated by rst so no beat is offered while reset is held.
    assign in_ready  = ~rst & (state_q == ST_ACC);
    assign out_valid = (state_q == ST_OUT);
    assign out_sum   = sum_q;
    assign out_count = ocnt_q;
    assign out_ovf   = oovf_q;

    assign accept_s   = in_valid & in_ready;
    assign sum_s      = {1'b0, acc_q} + {{(ACC_W + 1 - IN_W){1'b0}}, in_p};
    assign ovf_next_s = ovf_q | sum_s[ACC_W];
    // Once saturated the accumulator stays pinned for the rest of the group.
    assign acc_next_s = ((SAT != 0) && ovf_next_s) ? {ACC_W{1'b1}} : sum_s[ACC_W-1:0];
    assign cnt_next_s = count_q + {{(CW - 1){1'b0}}, 1'b1};
    assign close_s    = accept_s & ~clr & (in_last | (cnt_next_s == CW'(MAX_TERMS)));

    // Next-state logic for the accumulate/output handshake.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        count_d = count_q;
        ovf_d   = ovf_q;
        sum_d   = sum_q;
        ocnt_d  = ocnt_q;
        oovf_d  = oovf_q;
        case (state_q)
            ST_ACC: begin
                if (clr) begin
                    acc_d   = {ACC_W{1'b0}};
                    count_d = {CW{1'b0}};
                    ovf_d   = 1'b0;
                end else if (accept_s) begin
                    acc_d   = acc_next_s;
                    count_d = cnt_next_s;
                    ovf_d   = ovf_next_s;
                    if (close_s) begin
                        sum_d   = acc_next_s;
                        ocnt_d  = cnt_next_s;
                        oovf_d  = ovf_next_s;
                        state_d = ST_OUT;
                    end else begin
                        state_d = ST_ACC;
                    end
                end else begin
                    state_d = ST_ACC;
                end
            end
            ST_OUT: begin
                if (out_ready) begin
                    acc_d   = {ACC_W{1'b0}};
                    count_d = {CW{1'b0}};
                    ovf_d   = 1'b0;
                    state_d = ST_ACC;
                end else begin
                    state_d = ST_OUT;
                end
            end
            default: begin
                state_d = ST_ACC;
            end
        endcase
    end

    // State and result registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_ACC;
            acc_q   <= {ACC_W{1'b0}};
            count_q <= {CW{1'b0}};
            ovf_q   <= 1'b0;
            sum_q   <= {ACC_W{1'b0}};
            ocnt_q  <= {CW{1'b0}};
            oovf_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
            sum_q   <= sum_d;
            ocnt_q  <= ocnt_d;
            oovf_q  <= oovf_d;
        end
    end

endmodule

// File: tb/tb_prod_accum.sv
// Directed bench for prod_accum: four instances share stimulus, each covering
// a different parameter set (default, term limit 4, 10-bit wrap, 10-bit saturate).
module tb_prod_accum;

    logic       clk;
    logic       rst;
    logic [7:0] in_p;
    logic       in_valid;
    logic       in_last;
    logic       clr;
    logic       out_ready;

    logic        rdy0, rdyt, rdyw, rdys;
    logic [15:0] sum0, sumt;
    logic [9:0]  sumw, sums;
    logic [4:0]  cnt0;
    logic [2:0]  cntt;
    logic [3:0]  cntw, cnts;
    logic        ovf0, ovft, ovfw, ovfs;
    logic        val0, valt, valw, vals;

    int checks = 0;
    int errors = 0;

    prod_accum dut0 (
        .clk(clk), .rst(rst), .in_p(in_p), .in_valid(in_valid), .in_last(in_last),
        .in_ready(rdy0), .clr(clr), .out_sum(sum0), .out_count(cnt0), .out_ovf(ovf0),
        .out_valid(val0), .out_ready(out_ready)
    );

    prod_accum #(.MAX_TERMS(4)) dut_t (
        .clk(clk), .rst(rst), .in_p(in_p), .in_valid(in_valid), .in_last(in_last),
        .in_ready(rdyt), .clr(clr), .out_sum(sumt), .out_count(cntt), .out_ovf(ovft),
        .out_valid(valt), .out_ready(out_ready)
    );

    prod_accum #(.ACC_W(10), .SAT(0)) dut_w (
        .clk(clk), .rst(rst), .in_p(in_p), .in_valid(in_valid), .in_last(in_last),
        .in_ready(rdyw), .clr(clr), .out_sum(sumw), .out_count(cntw), .out_ovf(ovfw),
        .out_valid(valw), .out_ready(out_ready)
    );

    prod_accum #(.ACC_W(10), .SAT(1)) dut_s (
        .clk(clk), .rst(rst), .in_p(in_p), .in_valid(in_valid), .in_last(in_last),
        .in_ready(rdys), .clr(clr), .out_sum(sums), .out_count(cnts), .out_ovf(ovfs),
        .out_valid(vals), .out_ready(out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int got, input int exp);
        checks = checks + 1;
        if (got != exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One accepted beat; returns at the next falling edge with in_valid low.
    task automatic send(input logic [7:0] p, input logic last);
        in_p     = p;
        in_last  = last;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic handoff();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; in_p = 8'd0; in_valid = 1'b0; in_last = 1'b0;
        clr = 1'b0; out_ready = 1'b0;
        @(negedge clk);

        // Reset held two cycles with a valid beat of 200 offered.
        in_valid = 1'b1; in_p = 8'd200;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check_eq("rst_in_ready", int'(rdy0), 0);
            check_eq("rst_out_valid", int'(val0), 0);
        end
        check_eq("rst_out_sum", int'(sum0), 0);
        rst = 1'b0; in_valid = 1'b0;
        #1;
        check_eq("post_rst_ready", int'(rdy0), 1);

        // Basic group 15+30+45.
        send(8'd15, 1'b0);
        send(8'd30, 1'b0);
        check_eq("mid_group_valid", int'(val0), 0);
        send(8'd45, 1'b1);
        check_eq("basic_valid", int'(val0), 1);
        check_eq("basic_sum", int'(sum0), 90);
        check_eq("basic_count", int'(cnt0), 3);
        check_eq("basic_ovf", int'(ovf0), 0);

        // Backpressure: result held, input ignored.
        in_valid = 1'b1; in_p = 8'd99; in_last = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_eq("bp_sum", int'(sum0), 90);
            check_eq("bp_ready", int'(rdy0), 0);
            check_eq("bp_valid", int'(val0), 1);
        end
        in_valid = 1'b0; in_last = 1'b0;
        handoff();
        check_eq("handoff_valid", int'(val0), 0);
        check_eq("handoff_ready", int'(rdy0), 1);

        // Single-beat group.
        send(8'd7, 1'b1);
        check_eq("single_sum", int'(sum0), 7);
        check_eq("single_count", int'(cnt0), 1);
        handoff();

        // clr with a simultaneous accepted beat discards it.
        send(8'd10, 1'b0);
        send(8'd20, 1'b0);
        clr = 1'b1;
        check_eq("clr_beat_ready", int'(rdy0), 1);
        send(8'd40, 1'b1);
        clr = 1'b0;
        check_eq("clr_no_close", int'(val0), 0);
        send(8'd5, 1'b1);
        check_eq("clr_sum", int'(sum0), 5);
        check_eq("clr_count", int'(cnt0), 1);
        clr = 1'b1;
        @(negedge clk);
        @(negedge clk);
        clr = 1'b0;
        check_eq("clr_out_valid", int'(val0), 1);
        check_eq("clr_out_sum", int'(sum0), 5);
        handoff();

        // Term limit of 4 closes without in_last.
        do_reset();
        for (int i = 0; i < 3; i++) send(8'd225, 1'b0);
        check_eq("term_not_yet", int'(valt), 0);
        send(8'd225, 1'b0);
        check_eq("term_valid", int'(valt), 1);
        check_eq("term_sum", int'(sumt), 900);
        check_eq("term_count", int'(cntt), 4);
        handoff();
        send(8'd3, 1'b1);
        check_eq("term_next_sum", int'(sumt), 3);
        check_eq("term_next_count", int'(cntt), 1);
        handoff();

        // Overflow: 5 x 225 = 1125 in 10 bits.
        do_reset();
        for (int i = 0; i < 4; i++) send(8'd225, 1'b0);
        send(8'd225, 1'b1);
        check_eq("wrap_sum", int'(sumw), 101);
        check_eq("wrap_ovf", int'(ovfw), 1);
        check_eq("wrap_count", int'(cntw), 5);
        check_eq("sat_sum", int'(sums), 1023);
        check_eq("sat_ovf", int'(ovfs), 1);
        check_eq("wide_sum", int'(sum0), 1125);
        check_eq("wide_ovf", int'(ovf0), 0);
        handoff();
        send(8'd1, 1'b1);
        check_eq("sat_next_sum", int'(sums), 1);
        check_eq("sat_next_ovf", int'(ovfs), 0);
        check_eq("wrap_next_ovf", int'(ovfw), 0);
        handoff();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
